// File: rtl/bus_dma.sv
// bus_dma: bus initiator for the 8-bit data memory/IO block.
// Runs an ascending block copy (read/write pairs) or a constant fill of LEN
// bytes, then pulses DONE for one cycle. All outputs are registered: the
// next-state logic also computes the bus values for the coming cycle.
// Optional macro BUS_DMA_VERIFY_EN adds a read-back (VF) cycle after each
// write below the IO range and a sticky ERR flag for mismatches.
module bus_dma #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          START,
    input  logic          MODE,
    input  logic [AW-1:0] SRC,
    input  logic [AW-1:0] DST,
    input  logic [AW-1:0] LEN,
    input  logic [DW-1:0] FILL,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] DATA,
    output logic          MW,
    input  logic [DW-1:0] Q
);
`ifdef BUS_DMA_VERIFY_EN
    // Addresses at or above this are IO registers and are never read back.
    localparam logic [AW-1:0] IO_BASE = AW'(248);
`endif

    typedef enum logic [2:0] {
        IDLE, RD, WR, FIN
`ifdef BUS_DMA_VERIFY_EN
        , VF
`endif
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] src_ptr, src_n, dst_ptr, dst_n, rem, rem_n;
    logic [DW-1:0] dbuf, dbuf_n, fill_q, fill_n;
    logic          mode_q, mode_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] data_n;
    logic          mw_n, busy_n, done_n;
`ifdef BUS_DMA_VERIFY_EN
    logic          err_set;
`endif

    // Next state, datapath updates, and the registered bus values for the next cycle.
    always_comb begin
        state_n = state;
        src_n   = src_ptr;
        dst_n   = dst_ptr;
        rem_n   = rem;
        dbuf_n  = dbuf;
        fill_n  = fill_q;
        mode_n  = mode_q;
        addr_n  = '0;
        data_n  = DATA;
        mw_n    = 1'b0;
`ifdef BUS_DMA_VERIFY_EN
        err_set = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (START) begin
                    src_n  = SRC;
                    dst_n  = DST;
                    rem_n  = LEN;
                    fill_n = FILL;
                    mode_n = MODE;
                    if (LEN == '0)  state_n = FIN;
                    else if (MODE)  state_n = WR;
                    else            state_n = RD;
                end
            end
            RD: begin
                dbuf_n  = Q;
                src_n   = src_ptr + 1'b1;
                state_n = WR;
            end
            WR: begin
                dst_n = dst_ptr + 1'b1;
                rem_n = rem - 1'b1;
`ifdef BUS_DMA_VERIFY_EN
                // ADDR still holds the address being written this cycle.
                if (ADDR < IO_BASE) state_n = VF;
                else
`endif
                if (rem_n == '0)    state_n = FIN;
                else if (mode_q)    state_n = WR;
                else                state_n = RD;
            end
`ifdef BUS_DMA_VERIFY_EN
            VF: begin
                // DATA is held from the write cycle, so it is the byte to compare.
                if (Q != DATA) err_set = 1'b1;
                if (rem == '0)      state_n = FIN;
                else if (mode_q)    state_n = WR;
                else                state_n = RD;
            end
`endif
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        case (state_n)
            RD: addr_n = src_n;
            WR: begin
                addr_n = dst_n;
                data_n = mode_n ? fill_n : dbuf_n;
                mw_n   = 1'b1;
            end
`ifdef BUS_DMA_VERIFY_EN
            VF: addr_n = ADDR;
`endif
            default: ;
        endcase
    end

    assign busy_n = (state_n == RD) || (state_n == WR)
`ifdef BUS_DMA_VERIFY_EN
                    || (state_n == VF)
`endif
                    ;
    assign done_n = (state_n == FIN);

    // State, datapath and output registers; reset aborts any transfer at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            rem     <= '0;
            dbuf    <= '0;
            fill_q  <= '0;
            mode_q  <= 1'b0;
            ADDR    <= '0;
            DATA    <= '0;
            MW      <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_n;
            src_ptr <= src_n;
            dst_ptr <= dst_n;
            rem     <= rem_n;
            dbuf    <= dbuf_n;
            fill_q  <= fill_n;
            mode_q  <= mode_n;
            ADDR    <= addr_n;
            DATA    <= data_n;
            MW      <= mw_n;
            BUSY    <= busy_n;
            DONE    <= done_n;
        end
    end

`ifdef BUS_DMA_VERIFY_EN
    // Sticky read-back error, cleared when a new command is accepted.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                    ERR <= 1'b0;
        else if (state == IDLE && START) ERR <= 1'b0;
        else if (err_set)                ERR <= 1'b1;
    end
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bus_dma.sv
// Testbench for bus_dma: memory/IO bus model plus a transfer-level reference
// model (byte list and cycle count computed from the command alone).
module tb_bus_dma;
    logic       CLK = 1'b0, RESET_N = 1'b1, START = 1'b0, MODE = 1'b0;
    logic [7:0] SRC = '0, DST = '0, LEN = '0, FILL = '0;
    logic       BUSY, DONE, ERR, MW;
    logic [7:0] ADDR, DATA, Q;

    int checks = 0, failures = 0;
    int last_n;
    logic [7:0] bus_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ioa, iob;
    bit         kill_en = 1'b0;
    logic [7:0] exp_a [$];
    logic [7:0] exp_d [$];

`ifdef BUS_DMA_VERIFY_EN
    localparam bit VF_ON = 1'b1;
`else
    localparam bit VF_ON = 1'b0;
`endif

    bus_dma #(.AW(8), .DW(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .MODE(MODE),
        .SRC(SRC), .DST(DST), .LEN(LEN), .FILL(FILL),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .ADDR(ADDR), .DATA(DATA), .MW(MW), .Q(Q)
    );

    always #5 CLK = ~CLK;

    // Bus: 248/249 read IOA/IOB, 250-255 read 0, else memory. kill_en zeroes the read-back of 0x31.
    assign Q = (kill_en && !MW && BUSY && ADDR == 8'h31) ? 8'h00 :
               (ADDR == 8'd248) ? ioa :
               (ADDR == 8'd249) ? iob :
               (ADDR >= 8'd250) ? 8'h00 : bus_mem[ADDR];

    always @(posedge CLK) if (MW) bus_mem[ADDR] = DATA;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        if (a == 8'd248) return ioa;
        if (a == 8'd249) return iob;
        if (a >= 8'd250) return 8'h00;
        return ref_mem[a];
    endfunction

    // Reference transfer: ascending byte-by-byte, so overlapping copies propagate naturally.
    task automatic model(input bit mode, input logic [7:0] src, dst, len, fill);
        logic [7:0] s, d, b;
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < int'(len); i++) begin
            s = src + 8'(i);
            d = dst + 8'(i);
            b = mode ? fill : model_rd(s);
            ref_mem[d] = b;
            exp_a.push_back(d);
            exp_d.push_back(b);
        end
    endtask

    // Cycles from accept edge to DONE: one per fill byte, two per copy byte, +1 per read-back, +1 for FIN.
    function automatic int exp_cycles(input bit mode);
        int c = 1;
        foreach (exp_a[i]) begin
            c += mode ? 1 : 2;
            if (VF_ON && exp_a[i] < 8'd248) c++;
        end
        return c;
    endfunction

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 256; i++) if (bus_mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic xfer(input bit mode, input logic [7:0] src, dst, len, fill,
                        input int pulse_at, input bit fin_start, input bit exp_err, input string tag);
        int n, wr, badw, ec;
        ref_mem = bus_mem;
        model(mode, src, dst, len, fill);
        ec = exp_cycles(mode);
        @(negedge CLK);
        MODE = mode; SRC = src; DST = dst; LEN = len; FILL = fill; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        MODE = 1'($urandom); SRC = 8'($urandom); DST = 8'($urandom);
        LEN = 8'($urandom); FILL = 8'($urandom);
        n = 1; wr = 0; badw = 0;
        while (!DONE && n < 1000) begin
            if (MW) begin
                if (wr < exp_a.size()) begin
                    check({tag, "_waddr"}, ADDR, exp_a[wr]);
                    check({tag, "_wdata"}, DATA, exp_d[wr]);
                end
                wr++;
            end
            if (MW && !BUSY) badw++;
            START = (n == pulse_at);
            @(posedge CLK); #1;
            n++;
        end
        last_n = n;
        check({tag, "_done"}, DONE, 1'b1);
        check({tag, "_latency"}, n, ec);
        check({tag, "_writes"}, wr, len);
        check({tag, "_mw_idle"}, badw, 0);
        check({tag, "_fin_bus"}, {BUSY, MW}, 2'b00);
        check({tag, "_err"}, ERR, exp_err);
        check({tag, "_mem"}, mem_diff(), 0);
        if (fin_start) begin
            START = 1'b1; MODE = 1'b1; DST = 8'h80; LEN = 8'd1; FILL = 8'h3C;
        end else begin
            START = 1'b0;
        end
        @(posedge CLK); #1;
        check({tag, "_pulse"}, {DONE, BUSY, MW}, 3'b000);
    endtask

    initial begin
        int n, wr;
        ioa = 8'hC3;
        iob = 8'h69;
        for (int i = 0; i < 256; i++) bus_mem[i] = 8'h00;

        #2 RESET_N = 1'b0;
        #1 check("reset_outputs", {ADDR, DATA, MW, BUSY, DONE, ERR}, 20'h0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;

        // Fill 0x10..0x13 with A5; 0x14 must stay untouched.
        bus_mem[8'h14] = 8'h77;
        xfer(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 0, 1'b0, 1'b0, "fill");
        check("fill_lat_const", last_n, VF_ON ? 9 : 5);
        check("fill_keep_14", bus_mem[8'h14], 8'h77);

        // Copy 3 bytes 0x00 -> 0x40.
        bus_mem[0] = 8'h11; bus_mem[1] = 8'h22; bus_mem[2] = 8'h33;
        xfer(1'b0, 8'h00, 8'h40, 8'd3, 8'h00, 0, 1'b0, 1'b0, "copy");
        check("copy_lat_const", last_n, VF_ON ? 10 : 7);
        check("copy_byte2", bus_mem[8'h42], 8'h33);

        // Copy to display IO registers 250/251.
        bus_mem[8'h20] = 8'h5A; bus_mem[8'h21] = 8'h96;
        xfer(1'b0, 8'h20, 8'd250, 8'd2, 8'h00, 0, 1'b0, 1'b0, "copy_io");
        check("ioc", bus_mem[250], 8'h5A);
        check("iod", bus_mem[251], 8'h96);

        // Destination wrap 255 -> 0.
        xfer(1'b1, 8'h00, 8'd255, 8'd2, 8'hE1, 0, 1'b0, 1'b0, "wrap");
        check("wrap_0", bus_mem[0], 8'hE1);

        // Copy sourcing IOA/IOB and a zero-reading IO address.
        xfer(1'b0, 8'd248, 8'h50, 8'd3, 8'h00, 0, 1'b0, 1'b0, "copy_from_io");

        // LEN = 0.
        xfer(1'b0, 8'h00, 8'h60, 8'd0, 8'h00, 0, 1'b0, 1'b0, "len0");
        check("len0_lat_const", last_n, 1);

        // START pulsed mid-transfer is ignored.
        xfer(1'b0, 8'h40, 8'h90, 8'd6, 8'h00, 3, 1'b0, 1'b0, "busy_start");

        // START in FIN ignored, then accepted in the following IDLE cycle.
        xfer(1'b1, 8'h00, 8'hA0, 8'd2, 8'h0F, 0, 1'b1, 1'b0, "fin_start");
        @(posedge CLK); #1;
        START = 1'b0;
        check("fin_start_accept", {BUSY, MW, ADDR, DATA}, {2'b11, 8'h80, 8'h3C});
        n = 0;
        while (!DONE && n < 100) begin @(posedge CLK); #1; n++; end
        check("fin_start_done", DONE, 1'b1);
        check("fin_start_mem", bus_mem[8'h80], 8'h3C);
        @(posedge CLK); #1;

        // Reset after 2 of 8 copy bytes: outputs drop at once, only 2 bytes land.
        for (int i = 0; i < 8; i++) bus_mem[i] = 8'(8'hB0 + i);
        ref_mem = bus_mem;
        model(1'b0, 8'h00, 8'h60, 8'd2, 8'h00);
        @(negedge CLK);
        MODE = 1'b0; SRC = 8'h00; DST = 8'h60; LEN = 8'd8; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        wr = 0; n = 0;
        while (wr < 2 && n < 100) begin
            if (MW) wr++;
            @(posedge CLK); #1;
            n++;
        end
        @(negedge CLK);
        RESET_N = 1'b0;
        #1 check("abort_outputs", {ADDR, DATA, MW, BUSY, DONE, ERR}, 20'h0);
        repeat (3) @(posedge CLK);
        #1 check("abort_mem", mem_diff(), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        xfer(1'b0, 8'h00, 8'h60, 8'd8, 8'h00, 0, 1'b0, 1'b0, "after_reset");

`ifdef BUS_DMA_VERIFY_EN
        // Corrupted read-back of the second byte sets ERR; the next START clears it.
        kill_en = 1'b1;
        xfer(1'b1, 8'h00, 8'h30, 8'd2, 8'h5A, 0, 1'b0, 1'b1, "vf_kill");
        kill_en = 1'b0;
        xfer(1'b1, 8'h00, 8'd252, 8'd1, 8'h44, 0, 1'b0, 1'b0, "vf_io");
        check("vf_io_lat_const", last_n, 2);
`endif

        // Randomized transfers over a randomized memory image.
        for (int i = 0; i < 256; i++) bus_mem[i] = 8'($urandom);
        ioa = 8'($urandom);
        iob = 8'($urandom);
        for (int t = 0; t < 24; t++) begin
            xfer(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)),
                 8'($urandom), int'($urandom_range(0, 5)), 1'b0, 1'b0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
